// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier product-accumulator slice:
// default widths and the accumulator control state encoding.
package mult_pkg;

  localparam int P_W_DEF   = 16;
  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 8;

  // 2'd3 is unreachable; the FSM decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add_u.sv
// Combinational unsigned saturating adder: a + zero-extended b,
// clamped to all-ones with ovf=1 when the A_W-bit sum carries out.
module sat_add_u #(
  parameter int A_W = 24,
  parameter int B_W = 16
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           ovf
);

  logic [A_W:0] full;

  assign full = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
  assign ovf  = full[A_W];
  assign sum  = ovf ? {A_W{1'b1}} : full[A_W-1:0];

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums a burst of LEN unsigned products into a saturating accumulator and
// returns one registered sum per burst over a valid/ready result link.
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [P_W-1:0]   p_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  state_e             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [LEN_W-1:0]   cnt;
  logic               ovf, add_ovf;
  logic               xfer;
  logic               last;

  sat_add_u #(.A_W(ACC_W), .B_W(P_W)) u_sat_add (
    .a   (acc),
    .b   (p_data),
    .sum (acc_sum),
    .ovf (add_ovf)
  );

  assign xfer = p_valid && (state == ST_ACCUM);
  assign last = (cnt == LEN_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block latch-free even on
  // paths that do not mention state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (xfer && last) state_nxt = ST_HOLD;
      ST_HOLD:  if (res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator, remaining-count and sticky overflow; all frozen in HOLD so
  // the presented result stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (xfer) begin
      acc <= acc_sum;
      cnt <= cnt - LEN_W'(1);
      ovf <= ovf | add_ovf;
    end
  end

  assign p_ready   = (state == ST_ACCUM);
  assign res_valid = (state == ST_HOLD);
  assign busy      = p_ready | res_valid;
  assign res_data  = acc;
  assign res_ovf   = ovf;

endmodule
